// File: rtl/prog_loader.sv
// Serial program loader: UART bytes -> little-endian 32-bit words -> program memory write port.
// Optional macro PROG_LOADER_PARITY_EN switches frames from 8-N-1 to 8-E-1 with parity checking.
module prog_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 100000,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS);

  localparam logic [CNT_W-1:0]  BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [TO_W-1:0]   TO_END    = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  state_t            r_state;
  rx_state_t         r_rxState;

  logic              r_rxMeta;
  logic              r_rxSync;
  logic              r_rxSyncD;

  logic [CNT_W-1:0]  r_bitCnt;
  logic [2:0]        r_bitIdx;
  logic [7:0]        r_shift;

  logic [31:0]       r_word;
  logic [1:0]        r_byteIdx;
  logic [ADDR_W-1:0] r_addr;
  logic [TO_W-1:0]   r_toCnt;
  logic              r_gotByte;
  logic              r_fullPend;
  logic              r_flushSent;

  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_wrEn;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [31:0]       r_wrData;
  logic [ADDR_W:0]   r_wordCount;

  logic              w_rxActive;
  logic              w_startEdge;
  logic              w_stopSample;
  logic              w_byteGood;
  logic              w_byteBad;
  logic [31:0]       w_wordNext;

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign wr_en      = r_wrEn;
  assign wr_addr    = r_wrAddr;
  assign wr_data    = r_wrData;
  assign word_count = r_wordCount;

  // Synchronizer flops reset to the idle-high level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxMeta  <= 1'b1;
      r_rxSync  <= 1'b1;
      r_rxSyncD <= 1'b1;
    end else begin
      r_rxMeta  <= rx;
      r_rxSync  <= r_rxMeta;
      r_rxSyncD <= r_rxSync;
    end
  end

  assign w_rxActive   = (r_state == LOAD) && !r_fullPend;
  assign w_startEdge  = w_rxActive && (r_rxState == RX_HUNT) && r_rxSyncD && !r_rxSync;
  assign w_stopSample = w_rxActive && (r_rxState == RX_STOP) && (r_bitCnt == BIT_END);

`ifdef PROG_LOADER_PARITY_EN
  logic r_parErr;
  assign w_byteGood = w_stopSample && r_rxSync && !r_parErr;
`else
  assign w_byteGood = w_stopSample && r_rxSync;
`endif
  assign w_byteBad  = w_stopSample && !w_byteGood;

  always_comb begin
    w_wordNext = r_word;
    case (r_byteIdx)
      2'd0:    w_wordNext[7:0]   = r_shift;
      2'd1:    w_wordNext[15:8]  = r_shift;
      2'd2:    w_wordNext[23:16] = r_shift;
      default: w_wordNext[31:24] = r_shift;
    endcase
  end

  // Bit-level receiver; samples mid-bit once the start bit survives the half-bit re-check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxState <= RX_HUNT;
      r_bitCnt  <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
`ifdef PROG_LOADER_PARITY_EN
      r_parErr  <= 1'b0;
`endif
    end else if (!w_rxActive) begin
      r_rxState <= RX_HUNT;
      r_bitCnt  <= '0;
    end else begin
      case (r_rxState)
        RX_HUNT: begin
          if (r_rxSyncD && !r_rxSync) begin
            r_rxState <= RX_START;
            r_bitCnt  <= '0;
          end
        end
        RX_START: begin
          if (r_bitCnt == HALF_END) begin
            r_bitCnt <= '0;
            r_bitIdx <= '0;
            r_rxState <= r_rxSync ? RX_HUNT : RX_DATA;
          end else begin
            r_bitCnt <= r_bitCnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (r_bitCnt == BIT_END) begin
            r_bitCnt <= '0;
            r_shift  <= {r_rxSync, r_shift[7:1]};
            if (r_bitIdx == 3'd7) begin
`ifdef PROG_LOADER_PARITY_EN
              r_rxState <= RX_PARITY;
`else
              r_rxState <= RX_STOP;
`endif
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end else begin
            r_bitCnt <= r_bitCnt + CNT_ONE;
          end
        end
`ifdef PROG_LOADER_PARITY_EN
        RX_PARITY: begin
          if (r_bitCnt == BIT_END) begin
            r_bitCnt  <= '0;
            r_parErr  <= ^{r_shift, r_rxSync};
            r_rxState <= RX_STOP;
          end else begin
            r_bitCnt <= r_bitCnt + CNT_ONE;
          end
        end
`endif
        RX_STOP: begin
          if (r_bitCnt == BIT_END) begin
            r_bitCnt  <= '0;
            r_rxState <= RX_HUNT;
          end else begin
            r_bitCnt <= r_bitCnt + CNT_ONE;
          end
        end
        default: begin
          r_rxState <= RX_HUNT;
          r_bitCnt  <= '0;
        end
      endcase
    end
  end

  // Session FSM: word assembly, memory writes, idle timeout, flush and full-memory termination.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_byteIdx   <= '0;
      r_addr      <= '0;
      r_toCnt     <= '0;
      r_gotByte   <= 1'b0;
      r_fullPend  <= 1'b0;
      r_flushSent <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
      r_wordCount <= '0;
    end else begin
      r_wrEn <= 1'b0;
      if (start && ((r_state == IDLE) || (r_state == DONE))) begin
        r_state     <= LOAD;
        r_word      <= '0;
        r_byteIdx   <= '0;
        r_addr      <= '0;
        r_toCnt     <= '0;
        r_gotByte   <= 1'b0;
        r_fullPend  <= 1'b0;
        r_flushSent <= 1'b0;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_wordCount <= '0;
      end else begin
        case (r_state)
          LOAD: begin
            if (r_fullPend) begin
              r_fullPend <= 1'b0;
              r_state    <= DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              if (w_byteGood) begin
                r_gotByte <= 1'b1;
                if (r_byteIdx == 2'd3) begin
                  r_wrEn      <= 1'b1;
                  r_wrAddr    <= r_addr;
                  r_wrData    <= w_wordNext;
                  r_word      <= '0;
                  r_byteIdx   <= '0;
                  r_wordCount <= r_wordCount + WC_ONE;
                  if (r_addr == ADDR_LAST) begin
                    r_fullPend <= 1'b1;
                  end else begin
                    r_addr <= r_addr + ADDR_ONE;
                  end
                end else begin
                  r_word    <= w_wordNext;
                  r_byteIdx <= r_byteIdx + 2'd1;
                end
              end
              if (w_byteBad) begin
                r_err <= 1'b1;
              end
              if (w_startEdge) begin
                r_toCnt <= '0;
              end else if ((r_rxState == RX_HUNT) && r_gotByte) begin
                if (r_toCnt == TO_END) begin
                  r_toCnt <= '0;
                  if (r_byteIdx != 2'd0) begin
                    r_state <= FLUSH;
                  end else begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                  end
                end else begin
                  r_toCnt <= r_toCnt + TO_ONE;
                end
              end
            end
          end
          FLUSH: begin
            if (!r_flushSent) begin
              r_flushSent <= 1'b1;
              r_wrEn      <= 1'b1;
              r_wrAddr    <= r_addr;
              r_wrData    <= r_word;
              r_word      <= '0;
              r_byteIdx   <= '0;
              r_wordCount <= r_wordCount + WC_ONE;
            end else begin
              r_flushSent <= 1'b0;
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven load sessions plus hand-written
// full-memory, mid-frame reset, glitch and (when PROG_LOADER_PARITY_EN is defined) parity sequences.
module tb_prog_loader;

  localparam int CPB    = 8;
  localparam int TO     = 200;
  localparam int AW     = 4;
  localparam int NVEC   = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rx;
  logic          busy;
  logic          done;
  logic          err;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   word_count;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] capAddr[$];
  logic [31:0]   capData[$];
  logic [AW:0]   capWc[$];

  typedef struct {
    logic [63:0] bytes;
    int          nBytes;
    int          badIdx;
    int          nWr;
    logic [63:0] expData;
    logic        expErr;
  } vec_t;

  vec_t vecs[NVEC];

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TO),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rx(rx),
    .busy(busy),
    .done(done),
    .err(err),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      capAddr.push_back(wr_addr);
      capData.push_back(wr_data);
      capWc.push_back(word_count);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearCapture();
    capAddr.delete();
    capData.delete();
    capWc.delete();
  endtask

  task automatic driveBit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit badStop, input bit badPar);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
`ifdef PROG_LOADER_PARITY_EN
    driveBit((^b) ^ badPar);
`else
    if (badPar) $display("[TB] parity request ignored in 8-N-1 build");
`endif
    driveBit(!badStop);
    driveBit(1'b1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busyAfterStart", {31'd0, busy}, 32'd1);
    checkOutput("doneAfterStart", {31'd0, done}, 32'd0);
  endtask

  task automatic waitDone(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic checkWrites(input string name, input int nWr, input logic [63:0] expData);
    checkOutput({name, "_nWrites"}, 32'(capAddr.size()), 32'(nWr));
    for (int w = 0; w < nWr && w < capAddr.size(); w++) begin
      checkOutput({name, "_addr"}, 32'(capAddr[w]), 32'(w));
      checkOutput({name, "_data"}, capData[w], expData[32*w +: 32]);
      checkOutput({name, "_wcAtWrite"}, 32'(capWc[w]), 32'(w + 1));
    end
  endtask

  task automatic applyStimulus(input int v);
    clearCapture();
    pulseStart();
    for (int i = 0; i < vecs[v].nBytes; i++)
      sendByte(vecs[v].bytes[8*i +: 8], (i == vecs[v].badIdx), 1'b0);
    waitDone($sformatf("vec%0d_doneReached", v));
    checkWrites($sformatf("vec%0d", v), vecs[v].nWr, vecs[v].expData);
    checkOutput($sformatf("vec%0d_wordCount", v), 32'(word_count), 32'(vecs[v].nWr));
    checkOutput($sformatf("vec%0d_err", v), {31'd0, err}, {31'd0, vecs[v].expErr});
    checkOutput($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd0);
    checkOutput($sformatf("vec%0d_done", v), {31'd0, done}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{64'hDEADBEEF_12345678, 8, -1, 2, 64'hDEADBEEF_12345678, 1'b0};
    vecs[1] = '{64'h0000_BBAA,         2, -1, 1, 64'h0000_BBAA,         1'b0};
    vecs[2] = '{64'h05_04030201,       5,  1, 1, 64'h05040301,          1'b1};
    vecs[3] = '{64'h0033_2211,         3, -1, 1, 64'h0033_2211,         1'b0};
    vecs[4] = '{64'hEFBE_ADDE,         4,  3, 1, 64'h00BE_ADDE,         1'b1};

    rst   = 1'b0;
    start = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_wrEn", {31'd0, wr_en}, 32'd0);
    checkOutput("rst_wrAddr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wrData", wr_data, 32'd0);
    checkOutput("rst_wordCount", 32'(word_count), 32'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle_done", {31'd0, done}, 32'd0);

    for (int v = 0; v < NVEC; v++) applyStimulus(v);

    // Fill all 16 words, then a 17th word must be ignored.
    clearCapture();
    pulseStart();
    for (int k = 0; k < 16; k++)
      for (int j = 0; j < 4; j++) sendByte(8'(16 * k + j), 1'b0, 1'b0);
    checkOutput("full_done", {31'd0, done}, 32'd1);
    checkOutput("full_busy", {31'd0, busy}, 32'd0);
    checkOutput("full_wordCount", 32'(word_count), 32'd16);
    for (int j = 0; j < 4; j++) sendByte(8'(j + 1), 1'b0, 1'b0);
    repeat (TO + 20) @(posedge clk);
    #1;
    checkOutput("full_nWrites", 32'(capAddr.size()), 32'd16);
    for (int k = 0; k < 16 && k < capAddr.size(); k++) begin
      checkOutput("full_addr", 32'(capAddr[k]), 32'(k));
      checkOutput("full_data", capData[k],
                  {8'(16 * k + 3), 8'(16 * k + 2), 8'(16 * k + 1), 8'(16 * k)});
    end
    checkOutput("full_wordCountAfter", 32'(word_count), 32'd16);

    // Reset in the middle of the 3rd byte of the first word.
    clearCapture();
    pulseStart();
    sendByte(8'h11, 1'b0, 1'b0);
    sendByte(8'h22, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (CPB + 4) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    checkOutput("midRst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midRst_done", {31'd0, done}, 32'd0);
    checkOutput("midRst_err", {31'd0, err}, 32'd0);
    checkOutput("midRst_wrEn", {31'd0, wr_en}, 32'd0);
    checkOutput("midRst_wrAddr", 32'(wr_addr), 32'd0);
    checkOutput("midRst_wrData", wr_data, 32'd0);
    checkOutput("midRst_wordCount", 32'(word_count), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rx  = 1'b1;
    rst = 1'b1;
    repeat (TO + 20) @(posedge clk);
    #1;
    checkOutput("midRst_noWrite", 32'(capAddr.size()), 32'd0);
    checkOutput("midRst_idleDone", {31'd0, done}, 32'd0);
    pulseStart();
    for (int j = 0; j < 4; j++) sendByte(8'(j + 1), 1'b0, 1'b0);
    waitDone("midRst_doneReached");
    checkWrites("midRst", 1, 64'h04030201);

    // Two-cycle low glitch must not produce a byte or an error.
    clearCapture();
    pulseStart();
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("glitch_err", {31'd0, err}, 32'd0);
    checkOutput("glitch_busy", {31'd0, busy}, 32'd1);
    checkOutput("glitch_noWrite", 32'(capAddr.size()), 32'd0);
    sendByte(8'h10, 1'b0, 1'b0);
    sendByte(8'h20, 1'b0, 1'b0);
    sendByte(8'h30, 1'b0, 1'b0);
    sendByte(8'h40, 1'b0, 1'b0);
    waitDone("glitch_doneReached");
    checkWrites("glitch", 1, 64'h40302010);
    checkOutput("glitch_errAfter", {31'd0, err}, 32'd0);

`ifdef PROG_LOADER_PARITY_EN
    clearCapture();
    pulseStart();
    sendByte(8'hA1, 1'b0, 1'b0);
    sendByte(8'hB2, 1'b0, 1'b1);
    sendByte(8'hC3, 1'b0, 1'b0);
    sendByte(8'hD4, 1'b0, 1'b0);
    sendByte(8'hE5, 1'b0, 1'b0);
    waitDone("parity_doneReached");
    checkWrites("parity", 1, 64'hE5D4C3A1);
    checkOutput("parity_err", {31'd0, err}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
